// File: rtl/sprite_pkg.sv
// Shared types and constants for the hero sprite compositor.
// Sprite geometry, animation timing and screen limits.
package sprite_pkg;

  typedef logic [4:0] pixel_t;

  localparam int SPR_W       = 32;
  localparam int SPR_H       = 32;
  localparam int ANIM_FRAMES = 4;
  localparam int ANIM_DIV    = 8;

  localparam pixel_t TRANSPARENT = 5'h00;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int AW = $clog2(ANIM_FRAMES);
  localparam int DW = $clog2(ANIM_DIV);

  localparam int ROM_AW = AW + YW + XW;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Per-frame sprite state: VS edge detect, shadow position/facing,
// visibility flag and walk-cycle animation index.
module sprite_anim_ctrl
  import sprite_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          VS,
  input  logic [9:0]    HeroX,
  input  logic [9:0]    HeroY,
  input  logic          Facing,
  input  logic          Moving,
  output logic [9:0]    SprX,
  output logic [9:0]    SprY,
  output logic          SprFacing,
  output logic          Visible,
  output logic [AW-1:0] Anim
);

  logic          vs_q, vs_d;
  logic [9:0]    sx_q, sx_d;
  logic [9:0]    sy_q, sy_d;
  logic          facing_q, facing_d;
  logic          visible_q, visible_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] anim_q, anim_d;
  logic          vs_fall;

  always_comb begin
    vs_d      = VS;
    sx_d      = sx_q;
    sy_d      = sy_q;
    facing_d  = facing_q;
    visible_d = visible_q;
    div_d     = div_q;
    anim_d    = anim_q;
    vs_fall   = vs_q & ~VS;
    if (vs_fall) begin
      sx_d      = HeroX;
      sy_d      = HeroY;
      facing_d  = Facing;
      visible_d = 1'b1;
      if (!Moving) begin
        div_d  = '0;
        anim_d = '0;
      end else if (div_q == DW'(ANIM_DIV - 1)) begin
        div_d  = '0;
        anim_d = anim_q + AW'(1);
      end else begin
        div_d  = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q      <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
      facing_q  <= 1'b0;
      visible_q <= 1'b0;
      div_q     <= '0;
      anim_q    <= '0;
    end else begin
      vs_q      <= vs_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      facing_q  <= facing_d;
      visible_q <= visible_d;
      div_q     <= div_d;
      anim_q    <= anim_d;
    end
  end

  assign SprX      = sx_q;
  assign SprY      = sy_q;
  assign SprFacing = facing_q;
  assign Visible   = visible_q;
  assign Anim      = anim_q;

endmodule

// File: rtl/hero_sprite_compositor.sv
// Two-stage pixel pipeline overlaying the hero sprite on the
// background stream via an external synchronous sprite ROM.
module hero_sprite_compositor
  import sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PixEn,
  input  logic              VS,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [4:0]        BgPixel,
  input  logic [9:0]        HeroX,
  input  logic [9:0]        HeroY,
  input  logic              Facing,
  input  logic              Moving,
  output logic [ROM_AW-1:0] RomAddr,
  input  logic [4:0]        RomData,
  output logic [4:0]        PixelOut,
  output logic              SpriteHit
);

  logic [9:0]    spr_x, spr_y;
  logic          spr_facing, visible;
  logic [AW-1:0] anim;

  sprite_anim_ctrl u_anim (
    .Clk       (Clk),
    .Reset     (Reset),
    .VS        (VS),
    .HeroX     (HeroX),
    .HeroY     (HeroY),
    .Facing    (Facing),
    .Moving    (Moving),
    .SprX      (spr_x),
    .SprY      (spr_y),
    .SprFacing (spr_facing),
    .Visible   (visible),
    .Anim      (anim)
  );

  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  pixel_t            bg1_q, bg1_d;
  logic              inbox1_q, inbox1_d;
  pixel_t            pix_q, pix_d;
  logic              hit_q, hit_d;

  logic [10:0]   lx, ly;
  logic [XW-1:0] mx;
  logic          inbox;

  // 11-bit deltas: the right/bottom edge clips instead of wrapping
  always_comb begin
    lx    = {1'b0, DrawX} - {1'b0, spr_x};
    ly    = {1'b0, DrawY} - {1'b0, spr_y};
    inbox = visible
          && (DrawX >= spr_x) && (lx < 11'(SPR_W))
          && (DrawY >= spr_y) && (ly < 11'(SPR_H))
          && (DrawX < 10'(H_ACTIVE))
          && (DrawY < 10'(V_ACTIVE));
    mx    = spr_facing ? ~lx[XW-1:0] : lx[XW-1:0];
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    bg1_d      = bg1_q;
    inbox1_d   = inbox1_q;
    pix_d      = pix_q;
    hit_d      = hit_q;
    if (PixEn) begin
      rom_addr_d = inbox ? {anim, ly[YW-1:0], mx} : '0;
      bg1_d      = BgPixel;
      inbox1_d   = inbox;
      if (inbox1_q && (RomData != TRANSPARENT)) begin
        pix_d = RomData;
        hit_d = 1'b1;
      end else begin
        pix_d = bg1_q;
        hit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      bg1_q      <= '0;
      inbox1_q   <= 1'b0;
      pix_q      <= '0;
      hit_q      <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      bg1_q      <= bg1_d;
      inbox1_q   <= inbox1_d;
      pix_q      <= pix_d;
      hit_q      <= hit_d;
    end
  end

  assign RomAddr   = rom_addr_q;
  assign PixelOut  = pix_q;
  assign SpriteHit = hit_q;

endmodule

// File: tb/tb_hero_sprite_compositor.sv
// Directed bench for hero_sprite_compositor with a small
// synchronous ROM model and hand-computed expectations.
module tb_hero_sprite_compositor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PixEn = 1'b0;
  logic        VS = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [4:0]  BgPixel = '0;
  logic [9:0]  HeroX = '0;
  logic [9:0]  HeroY = '0;
  logic        Facing = 1'b0;
  logic        Moving = 1'b0;
  logic [11:0] RomAddr;
  logic [4:0]  RomData = '0;
  logic [4:0]  PixelOut;
  logic        SpriteHit;

  int total = 0;
  int bad = 0;

  hero_sprite_compositor dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PixEn     (PixEn),
    .VS        (VS),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .BgPixel   (BgPixel),
    .HeroX     (HeroX),
    .HeroY     (HeroY),
    .Facing    (Facing),
    .Moving    (Moving),
    .RomAddr   (RomAddr),
    .RomData   (RomData),
    .PixelOut  (PixelOut),
    .SpriteHit (SpriteHit)
  );

  always #10 Clk = ~Clk;

  function automatic logic [4:0] rom(input logic [11:0] a);
    case (a)
      12'd0:    rom = 5'h07;
      12'd31:   rom = 5'h0A;
      12'd63:   rom = 5'h00;
      12'd1024: rom = 5'h0C;
      default:  rom = 5'h11;
    endcase
  endfunction

  always @(posedge Clk) RomData <= rom(RomAddr);

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [4:0] bg);
    @(negedge Clk);
    DrawX   = 10'(x);
    DrawY   = 10'(y);
    BgPixel = bg;
    PixEn   = 1'b1;
    @(negedge Clk);
    PixEn   = 1'b0;
  endtask

  task automatic vs_edge();
    @(negedge Clk);
    VS = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    VS = 1'b1;
    @(negedge Clk);
  endtask

  task automatic out(input string tag, input logic [4:0] p, input logic h);
    chk({tag, "_pix"}, 16'(PixelOut), 16'(p));
    chk({tag, "_hit"}, 16'(SpriteHit), 16'(h));
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_pix", 16'(PixelOut), 16'h0);
    chk("rst_hit", 16'(SpriteHit), 16'h0);
    chk("rst_addr", 16'(RomAddr), 16'h0);
    Reset = 1'b0;
    HeroX = 10'd100;
    HeroY = 10'd50;

    pix(100, 50, 5'h15);
    pix(101, 50, 5'h15);
    out("novs", 5'h15, 1'b0);
    chk("novs_addr", 16'(RomAddr), 16'h0);

    vs_edge();
    pix(100, 50, 5'h15);
    chk("org_addr", 16'(RomAddr), 16'd0);
    pix(131, 50, 5'h15);
    out("org", 5'h07, 1'b1);
    chk("c131_addr", 16'(RomAddr), 16'd31);
    repeat (4) @(negedge Clk);
    chk("hold_addr", 16'(RomAddr), 16'd31);
    out("hold", 5'h07, 1'b1);
    pix(132, 50, 5'h15);
    out("c131", 5'h0A, 1'b1);
    pix(133, 50, 5'h15);
    out("c132", 5'h15, 1'b0);

    Facing = 1'b1;
    vs_edge();
    Facing = 1'b0;
    pix(100, 51, 5'h16);
    chk("mir_addr", 16'(RomAddr), 16'd63);
    pix(101, 51, 5'h16);
    out("transp", 5'h16, 1'b0);
    chk("mir2_addr", 16'(RomAddr), 16'd62);
    pix(0, 0, 5'h01);
    out("mir2", 5'h11, 1'b1);

    Moving = 1'b1;
    repeat (8) vs_edge();
    pix(100, 50, 5'h15);
    chk("anim1_addr", 16'(RomAddr), 16'd1024);
    pix(0, 0, 5'h01);
    out("anim1", 5'h0C, 1'b1);
    repeat (24) vs_edge();
    pix(100, 50, 5'h15);
    chk("wrap_addr", 16'(RomAddr), 16'd0);
    repeat (8) vs_edge();
    pix(100, 50, 5'h15);
    chk("anim1b_addr", 16'(RomAddr), 16'd1024);
    Moving = 1'b0;
    vs_edge();
    pix(100, 50, 5'h15);
    chk("stop_addr", 16'(RomAddr), 16'd0);

    HeroX = 10'd620;
    vs_edge();
    pix(639, 50, 5'h15);
    chk("c639_addr", 16'(RomAddr), 16'd19);
    pix(0, 50, 5'h15);
    out("c639", 5'h11, 1'b1);
    chk("nowrap_addr", 16'(RomAddr), 16'd0);
    pix(11, 50, 5'h15);
    out("nowrap0", 5'h15, 1'b0);
    HeroX = 10'd300;
    pix(621, 50, 5'h15);
    out("nowrap11", 5'h15, 1'b0);
    chk("mid_addr", 16'(RomAddr), 16'd1);
    pix(300, 50, 5'h17);
    out("mid621", 5'h11, 1'b1);
    pix(0, 0, 5'h01);
    out("mid300", 5'h17, 1'b0);
    vs_edge();
    pix(301, 50, 5'h15);
    chk("new_addr", 16'(RomAddr), 16'd1);

    HeroX = 10'd639;
    vs_edge();
    pix(639, 50, 5'h15);
    chk("x639_addr", 16'(RomAddr), 16'd0);
    pix(0, 51, 5'h15);
    out("x639", 5'h07, 1'b1);
    pix(0, 0, 5'h01);
    out("x639_next", 5'h15, 1'b0);
    HeroX = 10'd100;
    HeroY = 10'd480;
    vs_edge();
    pix(100, 479, 5'h15);
    pix(0, 0, 5'h01);
    out("y480", 5'h15, 1'b0);

    HeroY = 10'd50;
    vs_edge();
    pix(100, 50, 5'h15);
    pix(101, 50, 5'h15);
    out("prerst", 5'h07, 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    out("midrst", 5'h00, 1'b0);
    chk("midrst_addr", 16'(RomAddr), 16'd0);
    Reset = 1'b0;
    pix(100, 50, 5'h15);
    pix(101, 50, 5'h15);
    out("hidden", 5'h15, 1'b0);
    vs_edge();
    pix(100, 50, 5'h15);
    pix(101, 50, 5'h15);
    out("shown", 5'h07, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
